// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// One request outstanding at a time; responses come back in order.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage: PC, single-outstanding imem handshake, skid buffer
// for decode stalls, and the IF/ID pipeline register with redirect/flush handling.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_stage_if.master       imem,
    input  logic                stall_d_i,
    input  logic                flush_d_i,
    input  logic                redirect_valid_i,
    input  logic [31:0]         redirect_pc_i,
    output logic [31:0]         instr_d_o,
    output logic [31:0]         pc_d_o,
    output logic [31:0]         pc_plus4_d_o,
    output logic                valid_d_o
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        kill_q, kill_d;
    logic [31:0] skid_q, skid_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic        load;
    logic [31:0] load_instr;
    logic [31:0] load_pc;

    // Request side depends only on registered state so memory inputs never loop back.
    assign imem.imem_req  = (state_q == StReq);
    assign imem.imem_addr = fetch_pc_q;

    assign instr_d_o    = ifid_instr_q;
    assign pc_d_o       = ifid_pc_q;
    assign pc_plus4_d_o = ifid_pc4_q;
    assign valid_d_o    = ifid_valid_q;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        kill_d       = kill_q;
        skid_d       = skid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        load         = 1'b0;
        load_instr   = skid_q;
        load_pc      = fetch_pc_q;

        case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                if (imem.imem_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (imem.imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = StReq;
                    end else begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        if (!stall_d_i) begin
                            load       = 1'b1;
                            load_instr = imem.imem_rdata;
                            load_pc    = fetch_pc_q;
                            state_d    = StReq;
                        end else begin
                            skid_d  = imem.imem_rdata;
                            state_d = StHold;
                        end
                    end
                end
            end
            StHold: begin
                if (!stall_d_i) begin
                    // pc already advanced past the buffered word
                    load       = 1'b1;
                    load_instr = skid_q;
                    load_pc    = fetch_pc_q - 32'd4;
                    state_d    = StReq;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            ifid_instr_d = load_instr;
            ifid_pc_d    = load_pc;
            ifid_pc4_d   = load_pc + 32'd4;
            ifid_valid_d = 1'b1;
        end else if (flush_d_i) begin
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end

        if (redirect_valid_i) begin
            fetch_pc_d   = {redirect_pc_i[31:2], 2'b00};
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            case (state_q)
                StReq: begin
                    // an accepted old-address request must have its response dropped
                    kill_d  = imem.imem_ready;
                    state_d = imem.imem_ready ? StWait : StReq;
                end
                StWait: begin
                    if (imem.imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = StReq;
                    end else begin
                        kill_d  = 1'b1;
                        state_d = StWait;
                    end
                end
                default: state_d = StReq;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            fetch_pc_q   <= RESET_PC;
            kill_q       <= 1'b0;
            skid_q       <= NOP_INSTR;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= 32'h0000_0000;
            ifid_pc4_q   <= 32'h0000_0004;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            kill_q       <= kill_d;
            skid_q       <= skid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

endmodule
